// File: rtl/fft_pkg.sv
// Shared definitions for the 8-point FFT datapath.
//   N_PTS / LOG2_N : frame size and index width
//   bank_st_e      : occupancy state of one frame bank
//   bitrev3()      : 3-bit index reversal used by both reorder stages
package fft_pkg;

    localparam int N_PTS  = 8;
    localparam int LOG2_N = 3;

    typedef enum logic {
        BANK_EMPTY = 1'b0,
        BANK_FULL  = 1'b1
    } bank_st_e;

    function automatic logic [LOG2_N-1:0] bitrev3(input logic [LOG2_N-1:0] idx);
        return {idx[0], idx[1], idx[2]};
    endfunction

endpackage

// File: rtl/p2s_bank.sv
// One frame bank: N_PTS x DATA_W registers, written all at once, read by index.
//   clk   : clock
//   we    : capture wdata into all words
//   wdata : full frame, word k in wdata[k]
//   raddr : word select for rdata
//   rdata : selected word (combinational from registers)
// Contents are intentionally not reset; the occupancy flags in the top gate use.
import fft_pkg::*;

module p2s_bank #(
    parameter int DATA_W = 16
) (
    input  logic                          clk,
    input  logic                          we,
    input  logic [N_PTS-1:0][DATA_W-1:0]  wdata,
    input  logic [LOG2_N-1:0]             raddr,
    output logic [DATA_W-1:0]             rdata
);

    logic [N_PTS-1:0][DATA_W-1:0] mem;

    always_ff @(posedge clk) begin
        if (we) mem <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/p2s_frame_out.sv
// FFT output stage: ping-pong capture of an 8-word parallel frame, serial
// drain over valid/ready.
//   clk, reset_n        : clock, async active-low reset
//   load_valid/ready    : parallel frame handshake, p_in0..p_in7 sampled on accept
//   s_out/valid/ready   : serial word stream, s_out is 0 when not valid
//   s_last              : marks the 8th word of a frame
//   s_index             : word position within the frame
// BITREV=1 reads the bank in bit-reversed index order.
import fft_pkg::*;

module p2s_frame_out #(
    parameter int DATA_W = 16,
    parameter bit BITREV = 1'b0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                load_valid,
    output logic                load_ready,
    input  logic [DATA_W-1:0]   p_in0,
    input  logic [DATA_W-1:0]   p_in1,
    input  logic [DATA_W-1:0]   p_in2,
    input  logic [DATA_W-1:0]   p_in3,
    input  logic [DATA_W-1:0]   p_in4,
    input  logic [DATA_W-1:0]   p_in5,
    input  logic [DATA_W-1:0]   p_in6,
    input  logic [DATA_W-1:0]   p_in7,
    output logic [DATA_W-1:0]   s_out,
    output logic                s_valid,
    input  logic                s_ready,
    output logic                s_last,
    output logic [LOG2_N-1:0]   s_index
);

    logic [N_PTS-1:0][DATA_W-1:0] frame;
    logic [1:0][DATA_W-1:0]       bank_rdata;
    logic [1:0]                   bank_we;
    bank_st_e                     bank_st [2];
    logic                         wr_bank;
    logic                         rd_bank;
    logic [LOG2_N-1:0]            cnt;
    logic [LOG2_N-1:0]            sel;
    logic                         load_acc;
    logic                         xfer;
    logic                         at_last;

    assign frame = {p_in7, p_in6, p_in5, p_in4, p_in3, p_in2, p_in1, p_in0};

    // Both flags come straight from registers, so s_ready never reaches load_ready.
    assign load_ready = (bank_st[wr_bank] == BANK_EMPTY);
    assign s_valid    = (bank_st[rd_bank] == BANK_FULL);
    assign load_acc   = load_valid && load_ready;
    assign xfer       = s_valid && s_ready;
    assign at_last    = (cnt == LOG2_N'(N_PTS-1));
    assign sel        = BITREV ? bitrev3(cnt) : cnt;

    generate
        for (genvar b = 0; b < 2; b++) begin : g_bank
            assign bank_we[b] = load_acc && (wr_bank == 1'(b));
            p2s_bank #(.DATA_W(DATA_W)) u_bank (
                .clk   (clk),
                .we    (bank_we[b]),
                .wdata (frame),
                .raddr (sel),
                .rdata (bank_rdata[b])
            );
        end
    endgenerate

    // A load always targets an EMPTY bank and a drain a FULL one, so a
    // simultaneous load and final transfer never touch the same bank.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int b = 0; b < 2; b++) bank_st[b] <= BANK_EMPTY;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            cnt     <= '0;
        end else begin
            if (load_acc) begin
                bank_st[wr_bank] <= BANK_FULL;
                wr_bank          <= ~wr_bank;
            end
            if (xfer) begin
                if (at_last) begin
                    bank_st[rd_bank] <= BANK_EMPTY;
                    rd_bank          <= ~rd_bank;
                end
                cnt <= cnt + 1'b1;  // 7 wraps to 0 for the next frame
            end
        end
    end

    assign s_out   = s_valid ? bank_rdata[rd_bank] : '0;
    assign s_last  = s_valid && at_last;
    assign s_index = cnt;

endmodule
